pwm_duty_sequencer: RTL

//  Conditions raw slide-switch inputs into a glitch-free 4-bit duty code for the PWM generator.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_duty_sequencer_sw_debounce.sv | 46 ++++
 rtl/pwm_duty_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the PWM duty sequencer slice.
// Holds the duty width and the ramp state encoding.
package pwm_pkg;

  localparam int DUTY_W = 4;

  typedef enum logic [1:0] {
    SETTLED   = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_duty_sequencer_sw_debounce.sv
// Two-flop synchroniser and counter debounce for slide switches.
// accept pulses in the cycle a new value is committed to sw_stable.
module sw_debounce #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             accept
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(DEB_CYCLES - 2);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  // Commit on the edge that brings cnt to DEB_CYCLES-1.
  assign accept = (sync2 == cand) && (cnt == CNT_ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      cnt       <= '0;
      sw_stable <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (accept) sw_stable <= cand;
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Debounced, period-aligned duty code source for the PWM stage.
// DUTY_SOFTSTART_EN selects slewed ramping; otherwise duty jumps at wraps.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES   = 50000,
  parameter int RAMP_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_raw,
  input  logic       period_wrap,
  output logic [3:0] duty_code,
  output logic       duty_valid,
  output logic       ramping,
  output logic [3:0] sw_stable
);

  logic accept;

  sw_debounce #(
    .WIDTH      (DUTY_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .accept    (accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_valid <= 1'b0;
    else if (accept) duty_valid <= 1'b1;
  end

`ifdef DUTY_SOFTSTART_EN
  localparam int TW =
    (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_PERIODS - 1);

  ramp_state_t   state;
  ramp_state_t   state_nx;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_nx;
  logic [3:0]    duty_nx;
  logic          step;

  assign step    = period_wrap && (tick == TICK_LAST);
  assign ramping = (state != SETTLED);

  always_comb begin
    state_nx = state;
    tick_nx  = tick;
    duty_nx  = duty_code;
    unique case (state)
      SETTLED: begin
        tick_nx = '0;
        if (duty_valid && sw_stable > duty_code)
          state_nx = RAMP_UP;
        else if (duty_valid && sw_stable < duty_code)
          state_nx = RAMP_DOWN;
      end
      RAMP_UP, RAMP_DOWN: begin
        if (period_wrap)
          tick_nx = step ? '0 : tick + TW'(1);
        // Direction follows the live target, so reversal keeps tick.
        if (step && sw_stable > duty_code)
          duty_nx = duty_code + 4'd1;
        else if (step && sw_stable < duty_code)
          duty_nx = duty_code - 4'd1;
        if (sw_stable > duty_nx)
          state_nx = RAMP_UP;
        else if (sw_stable < duty_nx)
          state_nx = RAMP_DOWN;
        else
          state_nx = SETTLED;
      end
      default: state_nx = SETTLED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SETTLED;
      tick      <= '0;
      duty_code <= '0;
    end else begin
      state     <= state_nx;
      tick      <= tick_nx;
      duty_code <= duty_nx;
    end
  end
`else
  assign ramping = (duty_code != sw_stable);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_code <= '0;
    else if (period_wrap && duty_valid) duty_code <= sw_stable;
  end
`endif

endmodule
